// File: rtl/tff_counter_ctrl.sv
// Sequencing controller for a WIDTH-bit toggle flip-flop bank forming a modulo-MOD up/down counter.
// The bank only ever updates as count ^ t_vec; t_vec is derived from state, commands and count.
module tff_counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             up,
  input  logic             wrap,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MOD - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg;
  logic             busy_reg, done_reg;
  logic [WIDTH-1:0] t_vec_next;
  logic [WIDTH-1:0] inc_t, dec_t;
  logic [WIDTH-1:0] restart_t;
  logic [WIDTH-1:0] load_clamped;
  logic             at_term, out_of_range;

  // Ripple toggle enables: a bit flips when all lower bits are 1 (up) or all 0 (down).
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_toggle
    if (gi == 0) begin : g_lsb
      assign inc_t[gi] = 1'b1;
      assign dec_t[gi] = 1'b1;
    end else begin : g_upper
      assign inc_t[gi] = &count_reg[gi-1:0];
      assign dec_t[gi] = ~|count_reg[gi-1:0];
    end
  end

  assign at_term      = up ? (count_reg == TERM_UP) : (count_reg == '0);
  assign out_of_range = ({1'b0, count_reg} >= MOD_EXT);
  assign restart_t    = count_reg ^ (up ? '0 : TERM_UP);
  assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? TERM_UP : load_val;

  always_comb begin
    t_vec_next = '0;
    state_next = state_reg;
    if (rst) begin
      state_next = IDLE;
    end else if (stop) begin
      state_next = IDLE;
    end else if (load) begin
      t_vec_next = count_reg ^ load_clamped;
      state_next = (state_reg == RUN || state_reg == PAUSED) ? RUN : IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) state_next = RUN;
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (out_of_range) begin
            t_vec_next = count_reg;
          end else if (at_term) begin
            if (wrap) t_vec_next = restart_t;
            else      state_next = DONE;
          end else begin
            t_vec_next = up ? inc_t : dec_t;
          end
        end
        PAUSED: begin
          if (!pause) state_next = RUN;
        end
        DONE: begin
          if (start) begin
            state_next = RUN;
            t_vec_next = restart_t;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_reg ^ t_vec_next;
      busy_reg  <= (state_next == RUN) || (state_next == PAUSED);
      done_reg  <= (state_next == DONE);
    end
  end

  assign count = count_reg;
  assign t_vec = t_vec_next;
  assign tc    = (state_reg == RUN) && !pause && at_term;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Self-checking bench: arithmetic reference model checked every cycle, plus directed literal checks.
module tb_tff_counter_ctrl;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic             up = 1'b1, wrap = 1'b1, load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] count, t_vec;
  logic             tc, busy, done;

  int tests = 0;
  int fails = 0;

  // Reference model: count as an integer, mode as a small code.
  int m_count = 0, m_state = M_IDLE;
  int n_count = 0, n_state = M_IDLE;
  bit m_valid = 1'b0;

  tff_counter_ctrl #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .up(up), .wrap(wrap), .load(load), .load_val(load_val),
    .count(count), .t_vec(t_vec), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int step_of(input int c, input bit dir_up);
    if (dir_up) return (c + 1) % MOD;
    return (c == 0) ? MOD - 1 : c - 1;
  endfunction

  // Model next state from the command rules, then compare DUT outputs mid-cycle.
  always @(negedge clk) begin
    int  exp_t;
    bit  term;
    term    = up ? (m_count == MOD - 1) : (m_count == 0);
    n_count = m_count;
    n_state = m_state;
    if (rst) begin
      n_count = 0; n_state = M_IDLE;
    end else if (stop) begin
      n_state = M_IDLE;
    end else if (load) begin
      n_count = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
      n_state = (m_state == M_RUN || m_state == M_PAUSED) ? M_RUN : M_IDLE;
    end else begin
      case (m_state)
        M_IDLE:   if (start) n_state = M_RUN;
        M_RUN: begin
          if (pause)                 n_state = M_PAUSED;
          else if (m_count >= MOD)   n_count = 0;
          else if (term && wrap)     n_count = up ? 0 : MOD - 1;
          else if (term)             n_state = M_DONE;
          else                       n_count = step_of(m_count, up);
        end
        M_PAUSED: if (!pause) n_state = M_RUN;
        default: if (start) begin
          n_state = M_RUN;
          n_count = up ? 0 : MOD - 1;
        end
      endcase
    end
    exp_t = rst ? 0 : (m_count ^ n_count);
    if (m_valid) begin
      chk("model_count", int'(count), m_count);
      chk("model_busy", int'(busy), int'(m_state == M_RUN || m_state == M_PAUSED));
      chk("model_done", int'(done), int'(m_state == M_DONE));
      chk("model_t_vec", int'(t_vec), exp_t);
      chk("model_tc", int'(tc), int'(m_state == M_RUN && !pause && term));
    end
  end

  always @(posedge clk) begin
    m_count <= n_count;
    m_state <= n_state;
    if (rst) m_valid <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);

    // Up, wrap: 0..9 then back to 0,1
    up = 1'b1; wrap = 1'b1; start = 1'b1;
    tick(); start = 1'b0; #1;
    chk("up_first", int'(count), 0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("up_seq", int'(count), i);
    end
    chk("up_tc_at_9", int'(tc), 1);
    chk("up_tvec_9to0", int'(t_vec), 9);
    tick(); chk("wrap_to_0", int'(count), 0);
    chk("tc_low_at_0", int'(tc), 0);
    tick(); chk("wrap_to_1", int'(count), 1);

    // Load 3, count down one-shot
    stop = 1'b1; tick(); stop = 1'b0;
    load = 1'b1; load_val = 4'd3; tick(); load = 1'b0;
    chk("load3", int'(count), 3);
    up = 1'b0; wrap = 1'b0; start = 1'b1; tick(); start = 1'b0; #1;
    chk("dn_start", int'(count), 3);
    tick(); chk("dn_2", int'(count), 2);
    tick(); chk("dn_1", int'(count), 1);
    tick(); chk("dn_0", int'(count), 0);
    chk("dn_tc", int'(tc), 1);
    tick();
    chk("oneshot_done", int'(done), 1);
    chk("oneshot_busy", int'(busy), 0);
    chk("oneshot_hold", int'(count), 0);
    start = 1'b1; tick(); start = 1'b0; #1;
    chk("restart_dn", int'(count), 9);
    chk("restart_busy", int'(busy), 1);

    // Clamp and stop-over-load priority
    stop = 1'b1; tick(); stop = 1'b0;
    load = 1'b1; load_val = 4'd12; tick(); load = 1'b0;
    chk("clamp12", int'(count), 9);
    load = 1'b1; stop = 1'b1; load_val = 4'd2; tick(); load = 1'b0; stop = 1'b0;
    chk("stop_wins_count", int'(count), 9);
    chk("stop_wins_busy", int'(busy), 0);

    // Pause at 5
    load = 1'b1; load_val = 4'd4; tick(); load = 1'b0;
    up = 1'b1; wrap = 1'b1; start = 1'b1; tick(); start = 1'b0;
    tick(); chk("pre_pause", int'(count), 5);
    pause = 1'b1; #1;
    chk("pause_tc", int'(tc), 0);
    chk("pause_tvec", int'(t_vec), 0);
    tick(); tick(); tick();
    chk("paused_count", int'(count), 5);
    chk("paused_busy", int'(busy), 1);
    chk("paused_tc", int'(tc), 0);
    pause = 1'b0;
    tick(); chk("resume_edge1", int'(count), 5);
    tick(); chk("resume_edge2", int'(count), 6);

    // Reset mid-run at 7, start held through reset
    tick(); chk("pre_rst", int'(count), 7);
    rst = 1'b1; start = 1'b1; #1;
    chk("rst_tvec", int'(t_vec), 0);
    tick();
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    tick();
    chk("rst_held_busy", int'(busy), 0);
    rst = 1'b0; tick(); start = 1'b0; #1;
    chk("post_rst_busy", int'(busy), 1);

    // Direction flip at 4
    tick(); tick(); tick(); tick();
    chk("flip_at_4", int'(count), 4);
    up = 1'b0;
    tick(); chk("flip_3", int'(count), 3);
    tick(); chk("flip_2", int'(count), 2);

    // Randomized phase, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 15) == 0);
      pause    = ($urandom_range(0, 7) == 0);
      start    = ($urandom_range(0, 3) == 0);
      up       = 1'($urandom_range(0, 1));
      wrap     = ($urandom_range(0, 3) != 0);
      load_val = WIDTH'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; stop = 1'b0; load = 1'b0; pause = 1'b0; start = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
